// File: rtl/pc_fetch_unit.sv
// Program-counter and instruction-register stage of the multicycle MIPS datapath.
// Selects the next PC, latches the fetched word, and tracks retires, JAL link and faults.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          COUNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         pc_we,
  input  logic [1:0]         pc_src,
  input  logic               ir_we,
  input  logic               alu_zero,
  input  logic [31:0]        reg_a_data,
  input  logic [31:0]        imem_data,
  input  logic               fault_clear,
  output logic [31:0]        imem_addr,
  output logic [31:0]        pc,
  output logic [31:0]        instruction,
  output logic [31:0]        link_addr,
  output logic               branch_taken,
  output logic [COUNT_W-1:0] retire_count,
  output logic               fault,
  output logic [31:0]        fault_pc
);

  typedef enum logic [1:0] {
    WE_HOLD     = 2'd0,
    WE_ALWAYS   = 2'd1,
    WE_IF_ZERO  = 2'd2,
    WE_RESERVED = 2'd3
  } pc_we_e;

  typedef enum logic [1:0] {
    SRC_SEQ    = 2'd0,
    SRC_BRANCH = 2'd1,
    SRC_REG    = 2'd2,
    SRC_JUMP   = 2'd3
  } pc_src_e;

  pc_we_e  we_mode;
  pc_src_e src_sel;

  assign we_mode = pc_we_e'(pc_we);
  assign src_sel = pc_src_e'(pc_src);

  logic [31:0] seq_pc;
  logic [31:0] br_pc;
  logic [31:0] jump_pc;
  logic [31:0] next_pc;
  logic        write_req;
  logic        misaligned;
  logic        fault_now;
  logic        pc_load;
  logic        taken;

  // Branch offset is relative to the already-advanced PC, so no extra +4 here.
  assign seq_pc  = pc + 32'd4;
  assign br_pc   = pc + {{14{instruction[15]}}, instruction[15:0], 2'b00};
  assign jump_pc = {pc[31:28], instruction[25:0], 2'b00};

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    next_pc    = seq_pc;
    write_req  = 1'b0;
    misaligned = 1'b0;
    case (src_sel)
      SRC_SEQ:    next_pc = seq_pc;
      SRC_BRANCH: next_pc = br_pc;
      SRC_REG:    next_pc = reg_a_data;
      SRC_JUMP:   next_pc = jump_pc;
      default:    next_pc = seq_pc;
    endcase
    case (we_mode)
      WE_ALWAYS:  write_req = 1'b1;
      WE_IF_ZERO: write_req = alu_zero;
      default:    write_req = 1'b0;
    endcase
    if (write_req && (src_sel == SRC_REG) && (reg_a_data[1:0] != 2'b00)) begin
      misaligned = 1'b1;
    end
  end

  assign fault_now = (we_mode == WE_RESERVED) || misaligned;
  assign pc_load   = write_req && !misaligned;
  assign taken     = (we_mode == WE_IF_ZERO) && alu_zero && !misaligned;
  assign imem_addr = pc;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, e.g. IR captures the word at the old PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      instruction  <= 32'h0;
      link_addr    <= 32'h0;
      branch_taken <= 1'b0;
      retire_count <= '0;
      fault        <= 1'b0;
      fault_pc     <= 32'h0;
    end else begin
      branch_taken <= taken;
      if (pc_load) begin
        pc <= next_pc;
      end
      if ((we_mode == WE_ALWAYS) && (src_sel == SRC_JUMP)) begin
        link_addr <= seq_pc;
      end
      if (ir_we) begin
        instruction  <= imem_data;
        retire_count <= retire_count + COUNT_W'(1);
      end
      // A fault in the same cycle as fault_clear wins and re-captures the PC.
      if (fault_now) begin
        fault <= 1'b1;
        if (!fault || fault_clear) begin
          fault_pc <= pc;
        end
      end else if (fault_clear) begin
        fault <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit: fetch, BEQ, JAL, JR, faults, wrap, async reset.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [1:0]  pc_we;
  logic [1:0]  pc_src;
  logic        ir_we;
  logic        alu_zero;
  logic [31:0] reg_a_data;
  logic [31:0] imem_data;
  logic        fault_clear;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic [31:0] link_addr;
  logic        branch_taken;
  logic [15:0] retire_count;
  logic        fault;
  logic [31:0] fault_pc;

  int checks = 0;
  int errors = 0;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .COUNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_we        (pc_we),
    .pc_src       (pc_src),
    .ir_we        (ir_we),
    .alu_zero     (alu_zero),
    .reg_a_data   (reg_a_data),
    .imem_data    (imem_data),
    .fault_clear  (fault_clear),
    .imem_addr    (imem_addr),
    .pc           (pc),
    .instruction  (instruction),
    .link_addr    (link_addr),
    .branch_taken (branch_taken),
    .retire_count (retire_count),
    .fault        (fault),
    .fault_pc     (fault_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    pc_we       = 2'd0;
    pc_src      = 2'd0;
    ir_we       = 1'b0;
    alu_zero    = 1'b0;
    reg_a_data  = 32'h0;
    fault_clear = 1'b0;
  endtask

  // One clock edge, then settle 1 time unit before sampling outputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    imem_data = 32'h0;
    rst_n = 1'b0;
    #12;
    cmp32("reset_pc", pc, 32'h0);
    cmp32("reset_imem_addr", imem_addr, 32'h0);
    cmp32("reset_instruction", instruction, 32'h0);
    cmp32("reset_link", link_addr, 32'h0);
    cmp32("reset_taken", {31'h0, branch_taken}, 32'h0);
    cmp32("reset_retire", {16'h0, retire_count}, 32'h0);
    cmp32("reset_fault", {31'h0, fault}, 32'h0);
    cmp32("reset_fault_pc", fault_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_fetch();
    idle_inputs();
    imem_data = 32'h2005_0007;
    ir_we = 1'b1; pc_we = 2'd1; pc_src = 2'd0;
    step();
    cmp32("if_pc", pc, 32'h4);
    cmp32("if_imem_addr", imem_addr, 32'h4);
    cmp32("if_instruction", instruction, 32'h2005_0007);
    cmp32("if_retire", {16'h0, retire_count}, 32'h1);
  endtask

  task automatic test_beq();
    // Fetch a BEQ with offset -2 words; PC advances to 8.
    idle_inputs();
    imem_data = 32'h1000_FFFE;
    ir_we = 1'b1; pc_we = 2'd1; pc_src = 2'd0;
    step();
    cmp32("beq_fetch_pc", pc, 32'h8);
    cmp32("beq_fetch_retire", {16'h0, retire_count}, 32'h2);
    idle_inputs();
    pc_we = 2'd2; pc_src = 2'd1; alu_zero = 1'b1;
    step();
    cmp32("beq_taken_pc", pc, 32'h0);
    cmp32("beq_taken_pulse", {31'h0, branch_taken}, 32'h1);
    idle_inputs();
    step();
    cmp32("beq_pulse_drop", {31'h0, branch_taken}, 32'h0);
    cmp32("beq_hold_pc", pc, 32'h0);
    // Back to 8 via two sequential writes, then a not-taken branch.
    pc_we = 2'd1; pc_src = 2'd0;
    step();
    step();
    cmp32("beq_return_pc", pc, 32'h8);
    idle_inputs();
    pc_we = 2'd2; pc_src = 2'd1; alu_zero = 1'b0;
    step();
    cmp32("beq_not_taken_pc", pc, 32'h8);
    cmp32("beq_not_taken_pulse", {31'h0, branch_taken}, 32'h0);
    cmp32("beq_retire_unchanged", {16'h0, retire_count}, 32'h2);
  endtask

  task automatic test_jal();
    idle_inputs();
    imem_data = 32'h0C00_0040;
    ir_we = 1'b1; pc_we = 2'd1; pc_src = 2'd0;
    step();
    cmp32("jal_fetch_pc", pc, 32'hC);
    idle_inputs();
    pc_we = 2'd1; pc_src = 2'd0;
    step();
    cmp32("jal_pre_pc", pc, 32'h10);
    cmp32("jal_link_untouched", link_addr, 32'h0);
    pc_src = 2'd3;
    step();
    cmp32("jal_pc", pc, 32'h100);
    cmp32("jal_link", link_addr, 32'h14);
    cmp32("jal_retire", {16'h0, retire_count}, 32'h3);
  endtask

  task automatic test_jr_fault();
    idle_inputs();
    pc_we = 2'd1; pc_src = 2'd2; reg_a_data = 32'h20;
    step();
    cmp32("jr_pc", pc, 32'h20);
    cmp32("jr_no_fault", {31'h0, fault}, 32'h0);
    reg_a_data = 32'h22;
    step();
    cmp32("jr_misaligned_pc", pc, 32'h20);
    cmp32("jr_fault", {31'h0, fault}, 32'h1);
    cmp32("jr_fault_pc", fault_pc, 32'h20);
    // Move PC, then raise a second fault: fault_pc must stick.
    idle_inputs();
    pc_we = 2'd1; pc_src = 2'd0;
    step();
    cmp32("fault_move_pc", pc, 32'h24);
    pc_we = 2'd3;
    step();
    cmp32("reserved_hold_pc", pc, 32'h24);
    cmp32("second_fault_pc", fault_pc, 32'h20);
    cmp32("second_fault_flag", {31'h0, fault}, 32'h1);
    fault_clear = 1'b1;
    step();
    cmp32("clear_vs_fault_flag", {31'h0, fault}, 32'h1);
    cmp32("clear_vs_fault_pc", fault_pc, 32'h24);
    idle_inputs();
    fault_clear = 1'b1;
    step();
    cmp32("clear_flag", {31'h0, fault}, 32'h0);
    idle_inputs();
  endtask

  task automatic test_wrap();
    idle_inputs();
    pc_we = 2'd1; pc_src = 2'd2; reg_a_data = 32'hFFFF_FFFC;
    step();
    cmp32("wrap_pre_pc", pc, 32'hFFFF_FFFC);
    pc_src = 2'd0;
    step();
    cmp32("wrap_pc", pc, 32'h0);
    // Boot-style reloads: IR refills with PC held, counter runs to its limit.
    idle_inputs();
    ir_we = 1'b1;
    imem_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 65532; i++) begin
      @(posedge clk);
    end
    #1;
    cmp32("retire_max", {16'h0, retire_count}, 32'h0000_FFFF);
    cmp32("boot_pc_held", pc, 32'h0);
    cmp32("boot_instruction", instruction, 32'hDEAD_BEEF);
    step();
    cmp32("retire_wrap", {16'h0, retire_count}, 32'h0);
    idle_inputs();
  endtask

  task automatic test_async_reset();
    idle_inputs();
    pc_we = 2'd1; pc_src = 2'd2; reg_a_data = 32'h40;
    step();
    idle_inputs();
    pc_we = 2'd3;
    step();
    idle_inputs();
    cmp32("async_pre_pc", pc, 32'h40);
    cmp32("async_pre_fault", {31'h0, fault}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    cmp32("async_pc", pc, 32'h0);
    cmp32("async_fault", {31'h0, fault}, 32'h0);
    cmp32("async_fault_pc", fault_pc, 32'h0);
    cmp32("async_retire", {16'h0, retire_count}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_beq();
    test_jal();
    test_jr_fault();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
